// File: rtl/rr_arb8_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
package rr_arb8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    // Arbiter control states: no owner, or one owner holding the resource.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/dec3to8_case.sv
// 3-to-8 one-hot decoder with enable; all-zero output while disabled.
module dec3to8_case (
    input  logic [2:0] in_i,
    input  logic       en_i,
    output logic [7:0] out_o
);

    // Decode the index into a single set bit when enabled.
    always_comb begin
        out_o = 8'h00;
        if (en_i) begin
            case (in_i)
                3'd0: out_o = 8'h01;
                3'd1: out_o = 8'h02;
                3'd2: out_o = 8'h04;
                3'd3: out_o = 8'h08;
                3'd4: out_o = 8'h10;
                3'd5: out_o = 8'h20;
                3'd6: out_o = 8'h40;
                3'd7: out_o = 8'h80;
                default: out_o = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/rr_pick8.sv
// Combinational rotate-priority picker: first set request bit starting at ptr,
// scanning ptr, ptr+1, ... modulo 8.
module rr_pick8
    import rr_arb8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // Scan from the farthest offset down so the nearest set bit to ptr wins last.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[ptr + IDX_W'(k)]) begin
                any = 1'b1;
                idx = ptr + IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/rr_arb8_ctrl.sv
// Round-robin arbiter for 8 requesters sharing one decoded select bus.
// A grant is held until done, the owner's request drops, or MAX_HOLD cycles
// elapse; every release is followed by one dead cycle and priority rotates to
// the requester after the released owner.
// Optional macro RR_ARB8_LOCK_EN adds a lock input that suppresses the hold
// limit while asserted.
//
// Handshake: req is level-held by each requester; gnt/gnt_idx/gnt_vld are
// registered and change only on clk (or async rst); done is a one-cycle pulse
// from the current owner and is ignored while no grant is active.
module rr_arb8_ctrl
    import rr_arb8_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
`ifdef RR_ARB8_LOCK_EN
    input  logic             lock,
`endif
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout,
    output state_e           state_dbg_o
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [IDX_W-1:0]   ptr_q,   ptr_d;
    logic [HOLD_W-1:0]  hold_q,  hold_d;
    logic               tmo_q,   tmo_d;

    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic               hold_lock;
    logic               rel_done, rel_drop, rel_limit, at_limit;

`ifdef RR_ARB8_LOCK_EN
    assign hold_lock = lock;
`else
    assign hold_lock = 1'b0;
`endif

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Release causes for the current owner; the hold limit is masked by lock.
    always_comb begin
        at_limit  = (hold_q == MAX_HOLD_C);
        rel_done  = done;
        rel_drop  = ~req[idx_q];
        rel_limit = at_limit & ~hold_lock;
    end

    // Next-state logic: grant from IDLE, hold/count or release from GRANT.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    idx_d   = pick_idx;
                    hold_d  = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (rel_done || rel_drop || rel_limit) begin
                    state_d = IDLE;
                    ptr_d   = idx_q + IDX_W'(1);
                    // Timeout flags only a release caused purely by the limit.
                    tmo_d   = rel_limit & ~rel_done & ~rel_drop;
                end else if (!at_limit) begin
                    hold_d  = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, owner, pointer, hold counter and timeout pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            tmo_q   <= tmo_d;
        end
    end

    assign gnt_vld     = (state_q == GRANT);
    assign gnt_idx     = idx_q;
    assign timeout     = tmo_q;
    assign state_dbg_o = state_q;

    dec3to8_case u_dec (
        .in_i  (idx_q),
        .en_i  (gnt_vld),
        .out_o (gnt)
    );

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Bench for rr_arb8_ctrl: directed scenarios plus random traffic, scored
// against an integer-level arbitration model through an expected queue.
module tb_rr_arb8_ctrl;
    import rr_arb8_pkg::*;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic       lock_v = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;
    state_e     st_dbg;

    int checks = 0;
    int errors = 0;

    // Expected output word: {timeout, gnt_vld, idx (0 if no grant), gnt}.
    logic [12:0] exp_q[$];

    // Reference model state.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_ptr   = 0;
    int m_tmo   = 0;

    rr_arb8_ctrl #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
`ifdef RR_ARB8_LOCK_EN
        .lock        (lock_v),
`endif
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .gnt_vld     (gnt_vld),
        .timeout     (timeout),
        .state_dbg_o (st_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    function automatic logic [12:0] actual_word();
        logic [2:0] ix;
        ix = gnt_vld ? gnt_idx : 3'd0;
        return {timeout, gnt_vld, ix, gnt};
    endfunction

    function automatic logic [12:0] model_word();
        logic [7:0] g;
        logic [2:0] ix;
        g  = 8'h00;
        ix = 3'd0;
        if (m_owner >= 0) begin
            g  = 8'h01 << m_owner;
            ix = 3'(m_owner);
        end
        return {(m_tmo != 0), (m_owner >= 0), ix, g};
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
        m_tmo   = 0;
    endtask

    // One clock of arbitration rules applied to the inputs sampled at the edge.
    task automatic model_step(input logic [7:0] r, input logic d, input logic l);
        bit a, b, c, lk;
`ifdef RR_ARB8_LOCK_EN
        lk = l;
`else
        lk = 1'b0;
        if (l) lk = 1'b0;
`endif
        m_tmo = 0;
        if (m_owner < 0) begin
            for (int k = 0; k < 8; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    m_cnt   = 1;
                end
            end
        end else begin
            a = d;
            b = !r[m_owner];
            c = (m_cnt >= MAX_HOLD) && !lk;
            if (a || b || c) begin
                m_tmo   = (c && !a && !b) ? 1 : 0;
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end else if (m_cnt < MAX_HOLD) begin
                m_cnt++;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic [7:0] r, input logic d, input logic l);
        @(negedge clk);
        req    = r;
        done   = d;
        lock_v = l;
        model_step(r, d, l);
        exp_q.push_back(model_word());
    endtask

    task automatic go_idle();
        for (int i = 0; i < 3; i++) drive(8'h00, 1'b0, 1'b0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [12:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", actual_word(), e);
                checks++;
                if (!$onehot0(gnt)) begin
                    errors++;
                    $display("FAIL onehot: got gnt %h want zero or one-hot", gnt);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] r;
        // Reset values while reset is held.
        #12;
        check("reset_vals", actual_word(), 13'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Grant to requester 2, then reset between edges.
        @(negedge clk);
        req = 8'h04;
        @(posedge clk);
        #1;
        check("pre_rst_grant", actual_word(), {1'b0, 1'b1, 3'd2, 8'h04});
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", actual_word(), 13'h0000);
        @(negedge clk);
        rst = 1'b0;
        req = 8'h00;
        model_reset();

        // After reset ptr=0: 0x84 picks index 2.
        drive(8'h84, 1'b0, 1'b0);
        drive(8'h84, 1'b1, 1'b0);
        go_idle();

        // Single requester, done, regrant two cycles later.
        drive(8'h08, 1'b0, 1'b0);
        drive(8'h08, 1'b0, 1'b0);
        drive(8'h08, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(8'h08, 1'b0, 1'b0);
        go_idle();

        // Rotation across all requesters with done on every grant.
        for (int i = 0; i < 20; i++) drive(8'hFF, (m_owner >= 0), 1'b0);
        go_idle();

        // Pure timeout, then done coinciding with the limit cycle.
        for (int i = 0; i < 7; i++) drive(8'h01, 1'b0, 1'b0);
        go_idle();
        for (int i = 0; i < 4; i++) drive(8'h01, 1'b0, 1'b0);
        drive(8'h01, 1'b1, 1'b0);
        go_idle();

        // Fairness: owner 5 released, next grant goes to 0.
        drive(8'h20, 1'b0, 1'b0);
        drive(8'h21, 1'b0, 1'b0);
        drive(8'h21, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(8'h21, 1'b0, 1'b0);
        go_idle();

`ifdef RR_ARB8_LOCK_EN
        // Locked owner holds past the limit; dropping req releases it.
        for (int i = 0; i < 12; i++) drive(8'h02, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b1);
        go_idle();
`endif

        // Random traffic: requests tend to persist so grants run long.
        r = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            drive(r, ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
        end
        go_idle();

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arb8_ctrl.md
Name: rr_arb8_ctrl

Overview:
- Round-robin arbiter/controller that shares one 8-way decoded resource among 8 requesters.
- Selects one requester, registers its 3-bit index, and drives the one-hot grant through a 3-to-8 decoder with enable (enable = grant valid).
- Holds the grant until the requester releases or a hold limit expires, then rotates priority.
- Sits between requester agents and the shared decoded select bus.

Parameters:
- MAX_HOLD, 4: max cycles one grant may be held before forced release; legal range 1..15.
- HOLD_W, 4: width of the hold counter; must hold MAX_HOLD.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  8  request vector, bit i = requester i; level-held while wanting the resource
- done  in  1  single-cycle release pulse from the current owner
- gnt  out  8  one-hot grant (decoded gnt_idx gated by gnt_vld); all-zero when no grant
- gnt_idx  out  3  index of current owner; valid only when gnt_vld=1
- gnt_vld  out  1  a grant is active
- timeout  out  1  one-cycle pulse when a grant is force-released at MAX_HOLD

Behaviour:
- Reset (async, active-high) values: gnt=8'h00, gnt_idx=3'd0, gnt_vld=0, timeout=0, ptr=3'd0, hold_cnt=0, state=IDLE.
- Reset asserted mid-grant clears gnt immediately, without waiting for a clock edge.
- State machine: IDLE, GRANT.
- IDLE, req==0: stay in IDLE; outputs hold their reset values.
- IDLE, req!=0: choose the first set bit scanning ptr, ptr+1, ... mod 8.
  - Next edge: gnt_idx = winner, gnt_vld=1, hold_cnt=1, state -> GRANT.
  - Latency from req to gnt is 1 cycle.
- GRANT release conditions, evaluated each cycle:
  - (a) done=1
  - (b) req[gnt_idx]=0
  - (c) hold_cnt==MAX_HOLD
- On any release: next edge sets gnt_vld=0, ptr=(gnt_idx+1) mod 8 (7 wraps to 0), state -> IDLE.
- Every release inserts one mandatory dead cycle with gnt=0 before the next grant. Back-to-back grants are therefore spaced 2 cycles apart.
- No release condition: hold_cnt increments.
- timeout=1 for exactly the cycle after release, and only when (c) is the sole cause.
  - If (a) or (b) coincides with (c), treat it as a normal release with no timeout.
- gnt_idx keeps its last value after release and is ignored while gnt_vld=0.
- New requests arriving during GRANT do not preempt the owner.
- A requester whose bit drops while in IDLE is simply not chosen; no sticky request state.
- gnt is always zero or one-hot; two bits set is a hard error.

Optional Feature:
- Macro: RR_ARB8_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - While lock=1 in GRANT, condition (c) is suppressed: no forced release, no timeout; hold_cnt saturates at MAX_HOLD.
  - done and req drop still release the grant.
- Undefined: no lock port; behaviour exactly as above.

Decomposition:
- Package rr_arb8_pkg holds:
  - state enum {IDLE, GRANT}
  - N_REQ=8
  - IDX_W=3
- Sub-module rr_pick8: combinational rotate-priority picker.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: any, idx[2:0].
- gnt decode reuses the team's existing 3-to-8 decoder with enable (dec3to8_case), with in=gnt_idx and en=gnt_vld.
- Counter, pointer and FSM stay in the top module.

Test Plan:
- Reset mid-grant: grant to req 8'h04, assert rst between clock edges -> gnt=8'h00 immediately; after deassert, ptr=0, so req 8'h84 gives gnt_idx=2.
- Single requester: req=8'h08 from IDLE -> next cycle gnt=8'h08, gnt_idx=3; done pulse -> gnt=0 next cycle; req still high -> regranted idx 3 two cycles after done.
- Rotation: req=8'hFF held, done each grant -> grant order 0,1,2,...,7,0 with one dead cycle between grants; ptr wraps 7->0.
- Timeout, MAX_HOLD=4: req=8'h01 held, no done -> gnt_vld high 4 cycles, then timeout=1 for 1 cycle, gnt=0; done coinciding with cycle 4 -> timeout stays 0.
- Fairness: owner idx 5, req=8'h21 -> after release, next grant goes to idx 0 (scan 6,7,0), not idx 5.
- With RR_ARB8_LOCK_EN, lock=1 on idx 1 -> grant held 10 cycles with no timeout; drop req[1] -> release next cycle.
